// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection scheduler and its phase timer:
//   - phase_e      : 3-bit phase encodings (7 is illegal)
//   - LIGHT_*      : one-hot light codes, {red,yellow,green}
//   - DEF_*        : default phase durations (in 1 s pulses) and timer width
//   - ns_light_of / ew_light_of : phase -> light decode for each road head
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_ALL_RED_A = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_ALL_RED_B = 3'd5,
        PH_WALK      = 3'd6
    } phase_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam int unsigned DEF_GREEN_S   = 10;
    localparam int unsigned DEF_YELLOW_S  = 2;
    localparam int unsigned DEF_ALL_RED_S = 1;
    localparam int unsigned DEF_WALK_S    = 8;
    localparam int unsigned DEF_CNT_W     = 5;

    function automatic logic [2:0] ns_light_of(input phase_e p);
        logic [2:0] l;
        l = LIGHT_RED;
        if (p == PH_NS_GREEN)  l = LIGHT_GRN;
        if (p == PH_NS_YELLOW) l = LIGHT_YEL;
        return l;
    endfunction

    function automatic logic [2:0] ew_light_of(input phase_e p);
        logic [2:0] l;
        l = LIGHT_RED;
        if (p == PH_EW_GREEN)  l = LIGHT_GRN;
        if (p == PH_EW_YELLOW) l = LIGHT_YEL;
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Counts 1 s ticks within the current phase and flags expiry.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count at 0 (phase entry)
//   tick     : 1 s pulse, advances t
//   hold     : freeze t once it reaches dur-1
//   dur      : duration of the current phase, in ticks
//   t        : current count
//   expire   : tick && t == dur-1
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic             hold,
    input  logic [CNT_W-1:0] dur,
    output logic [CNT_W-1:0] t,
    output logic             expire
);

    logic at_end;

    assign at_end = (t == (dur - CNT_W'(1)));
    assign expire = tick && at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            t <= '0;
        end else if (clear) begin
            t <= '0;
        end else if (tick && !(hold && at_end)) begin
            t <= t + CNT_W'(1);
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
// Grants green to one road at a time (NS / EW), inserts yellow and all-red
// clearance, and schedules a pedestrian WALK phase, all timed from pulse_1s.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pulse_1s     : one-clk pulse per second
//   ped_req      : pedestrian button (latched into ped_pending)
//   priority_ns  : holds NS green past GREEN_S while high (no ped pending)
//   ns_light     : NS head, one-hot {red,yellow,green}, registered
//   ew_light     : EW head, one-hot {red,yellow,green}, registered
//   walk         : pedestrian WALK indication, registered
//   ped_pending  : latched pedestrian request not yet served
//   phase        : current phase encoding
// Build option:
//   TRAFFIC_PED_SHORTEN_EN : a pending pedestrian cuts a green short once
//                            t >= GREEN_S/2 (exits on the next pulse).
// -----------------------------------------------------------------------------
module intersection_scheduler #(
    parameter int unsigned GREEN_S   = traffic_pkg::DEF_GREEN_S,
    parameter int unsigned YELLOW_S  = traffic_pkg::DEF_YELLOW_S,
    parameter int unsigned ALL_RED_S = traffic_pkg::DEF_ALL_RED_S,
    parameter int unsigned WALK_S    = traffic_pkg::DEF_WALK_S,
    parameter int unsigned CNT_W     = traffic_pkg::DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_1s,
    input  logic       ped_req,
    input  logic       priority_ns,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    import traffic_pkg::*;

`ifdef TRAFFIC_PED_SHORTEN_EN
    localparam bit SHORTEN_EN = 1'b1;
`else
    localparam bit SHORTEN_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HALF_GREEN = CNT_W'(GREEN_S / 2);

    phase_e           state;
    phase_e           next_state;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] t;
    logic             expire;
    logic             hold;
    logic             is_green;
    logic             shorten;
    logic             green_exit;
    logic             clear;

    // Duration of the phase currently being timed.
    always_comb begin
        dur = CNT_W'(ALL_RED_S);
        case (state)
            PH_NS_GREEN, PH_EW_GREEN:   dur = CNT_W'(GREEN_S);
            PH_NS_YELLOW, PH_EW_YELLOW: dur = CNT_W'(YELLOW_S);
            PH_ALL_RED_A, PH_ALL_RED_B: dur = CNT_W'(ALL_RED_S);
            PH_WALK:                    dur = CNT_W'(WALK_S);
            default:                    dur = CNT_W'(ALL_RED_S);
        endcase
    end

    assign is_green = (state == PH_NS_GREEN) || (state == PH_EW_GREEN);

    // NS priority only extends the green when nobody is waiting to cross.
    assign hold = (state == PH_NS_GREEN) && priority_ns && !ped_pending;

    // Early green exit for a waiting pedestrian; overrides NS priority.
    assign shorten = SHORTEN_EN && pulse_1s && ped_pending && is_green
                     && (t >= HALF_GREEN);

    assign green_exit = shorten || (expire && !hold);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .tick   (pulse_1s),
        .hold   (hold),
        .dur    (dur),
        .t      (t),
        .expire (expire)
    );

    always_comb begin
        next_state = state;
        case (state)
            PH_NS_GREEN:  if (green_exit) next_state = PH_NS_YELLOW;
            PH_NS_YELLOW: if (expire)     next_state = PH_ALL_RED_A;
            PH_ALL_RED_A: if (expire)     next_state = PH_EW_GREEN;
            PH_EW_GREEN:  if (green_exit) next_state = PH_EW_YELLOW;
            PH_EW_YELLOW: if (expire)     next_state = PH_ALL_RED_B;
            PH_ALL_RED_B: begin
                if (expire) next_state = ped_pending ? PH_WALK : PH_NS_GREEN;
            end
            PH_WALK:      if (expire)     next_state = PH_NS_GREEN;
            default:                      next_state = PH_ALL_RED_B;
        endcase
    end

    // Any phase change restarts the timer, so a pulse on the exit edge only
    // counts toward the phase being left.
    assign clear = (next_state != state);

    // Outputs are decoded from next_state so the registered lights line up
    // with the registered phase on every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PH_ALL_RED_B;
            ns_light    <= LIGHT_RED;
            ew_light    <= LIGHT_RED;
            walk        <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state    <= next_state;
            ns_light <= ns_light_of(next_state);
            ew_light <= ew_light_of(next_state);
            walk     <= (next_state == PH_WALK);
            // Clear on WALK entry takes precedence over a same-edge request.
            if ((next_state == PH_WALK) && (state != PH_WALK)) begin
                ped_pending <= 1'b0;
            end else if (ped_req && (state != PH_WALK)) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
module tb_intersection_scheduler;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

`ifdef TRAFFIC_PED_SHORTEN_EN
    localparam int unsigned EXP_PED_GREEN = 6;
`else
    localparam int unsigned EXP_PED_GREEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse_1s;
    logic       ped_req;
    logic       priority_ns;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    intersection_scheduler #(
        .GREEN_S   (10),
        .YELLOW_S  (2),
        .ALL_RED_S (1),
        .WALK_S    (8),
        .CNT_W     (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_1s    (pulse_1s),
        .ped_req     (ped_req),
        .priority_ns (priority_ns),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    // 1 s timebase: one pulse every 4 clocks.
    initial begin
        pulse_1s = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            pulse_1s = 1'b1;
            @(negedge clk);
            pulse_1s = 1'b0;
        end
    end

    // Lights always one-hot and never both roads non-red.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (!$onehot(ns_light) || !$onehot(ew_light) ||
                (ns_light !== RED && ew_light !== RED)) begin
                bad++;
                $display("FAIL safety: ns=%b ew=%b required one-hot with a red road", ns_light, ew_light);
            end
        end
    end

    function automatic logic [2:0] exp_ns(input int unsigned p);
        return (p == 0) ? GRN : (p == 1) ? YEL : RED;
    endfunction

    function automatic logic [2:0] exp_ew(input int unsigned p);
        return (p == 3) ? GRN : (p == 4) ? YEL : RED;
    endfunction

    task automatic next_pulse();
        do @(posedge clk); while (pulse_1s !== 1'b1);
        #1;
    endtask

    // Pulses spent in the current phase, including the one that ends it.
    task automatic run_phase(output int unsigned n);
        logic [2:0] start;
        start = phase;
        n = 0;
        do begin
            next_pulse();
            n++;
        end while (phase === start && n < 40);
    endtask

    task automatic wait_phase(input logic [2:0] target);
        int unsigned n;
        n = 0;
        while (phase !== target && n < 60) begin
            next_pulse();
            n++;
        end
        total++;
        if (phase !== target) begin
            bad++;
            $display("FAIL wait_phase: phase=%0d required %0d within 60 pulses", phase, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ped_req = 1'b0; priority_ns = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (phase !== 3'd5) begin bad++; $display("FAIL reset_phase: got %0d required 5", phase); end
        total++; if (ns_light !== RED) begin bad++; $display("FAIL reset_ns: got %b required %b", ns_light, RED); end
        total++; if (ew_light !== RED) begin bad++; $display("FAIL reset_ew: got %b required %b", ew_light, RED); end
        total++; if (walk !== 1'b0) begin bad++; $display("FAIL reset_walk: got %b required 0", walk); end
        total++; if (ped_pending !== 1'b0) begin bad++; $display("FAIL reset_ped: got %b required 0", ped_pending); end
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_cycle();
        int unsigned exp_n [7] = '{1, 10, 2, 1, 10, 2, 1};
        int unsigned exp_p [7] = '{0, 1, 2, 3, 4, 5, 0};
        int unsigned n;
        for (int i = 0; i < 7; i++) begin
            run_phase(n);
            total++; if (n !== exp_n[i]) begin bad++; $display("FAIL cycle_len[%0d]: got %0d pulses required %0d", i, n, exp_n[i]); end
            total++; if (phase !== 3'(exp_p[i])) begin bad++; $display("FAIL cycle_phase[%0d]: got %0d required %0d", i, phase, exp_p[i]); end
            total++; if (ns_light !== exp_ns(exp_p[i]) || ew_light !== exp_ew(exp_p[i]) || walk !== 1'b0) begin
                bad++; $display("FAIL cycle_lights[%0d]: ns=%b ew=%b walk=%b required ns=%b ew=%b walk=0",
                                i, ns_light, ew_light, walk, exp_ns(exp_p[i]), exp_ew(exp_p[i]));
            end
        end
    endtask

    task automatic test_ped_walk();
        int unsigned n;
        wait_phase(3'd3);
        @(negedge clk); ped_req = 1'b1;
        @(posedge clk); #1;
        total++; if (ped_pending !== 1'b1) begin bad++; $display("FAIL ped_set: got %b required 1", ped_pending); end
        @(negedge clk); ped_req = 1'b0;
        wait_phase(3'd5);
        total++; if (ped_pending !== 1'b1) begin bad++; $display("FAIL ped_held: got %b required 1", ped_pending); end
        // Request still high on the WALK-entry edge: the clear must win.
        @(negedge clk); ped_req = 1'b1;
        run_phase(n);
        total++; if (n !== 1 || phase !== 3'd6) begin bad++; $display("FAIL walk_entry: %0d pulses to phase %0d required 1 to 6", n, phase); end
        total++; if (walk !== 1'b1 || ns_light !== RED || ew_light !== RED) begin
            bad++; $display("FAIL walk_lights: walk=%b ns=%b ew=%b required 1 %b %b", walk, ns_light, ew_light, RED, RED);
        end
        total++; if (ped_pending !== 1'b0) begin bad++; $display("FAIL walk_clear: got %b required 0", ped_pending); end
        @(negedge clk); ped_req = 1'b0;
        @(negedge clk); ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
        total++; if (ped_pending !== 1'b0) begin bad++; $display("FAIL walk_ignore: got %b required 0", ped_pending); end
        run_phase(n);
        total++; if (n !== 8 || phase !== 3'd0) begin bad++; $display("FAIL walk_len: %0d pulses to phase %0d required 8 to 0", n, phase); end
        total++; if (walk !== 1'b0 || ns_light !== GRN) begin bad++; $display("FAIL walk_exit: walk=%b ns=%b required 0 %b", walk, ns_light, GRN); end
    endtask

    task automatic test_priority();
        @(negedge clk); priority_ns = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            next_pulse();
            total++; if (phase !== 3'd0) begin bad++; $display("FAIL prio_hold[%0d]: phase=%0d required 0", i, phase); end
        end
        @(negedge clk); priority_ns = 1'b0;
        next_pulse();
        total++; if (phase !== 3'd1 || ns_light !== YEL) begin bad++; $display("FAIL prio_release: phase=%0d ns=%b required 1 %b", phase, ns_light, YEL); end
    endtask

    task automatic test_priority_ped();
        int unsigned n;
        wait_phase(3'd0);
        @(negedge clk); priority_ns = 1'b1; ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
        run_phase(n);
        total++; if (n !== EXP_PED_GREEN || phase !== 3'd1) begin
            bad++; $display("FAIL prio_override: %0d pulses to phase %0d required %0d to 1", n, phase, EXP_PED_GREEN);
        end
        total++; if (ped_pending !== 1'b1) begin bad++; $display("FAIL prio_ped_pending: got %b required 1", ped_pending); end
        @(negedge clk); priority_ns = 1'b0;
    endtask

    task automatic test_reset_mid();
        int unsigned n;
        wait_phase(3'd3);
        @(negedge clk); ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
        repeat (4) next_pulse();
        total++; if (phase !== 3'd3) begin bad++; $display("FAIL midrst_pre: phase=%0d required 3", phase); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++; if (phase !== 3'd5) begin bad++; $display("FAIL midrst_phase: got %0d required 5", phase); end
        total++; if (ew_light !== RED || ns_light !== RED) begin bad++; $display("FAIL midrst_lights: ns=%b ew=%b required %b %b", ns_light, ew_light, RED, RED); end
        total++; if (ped_pending !== 1'b0 || walk !== 1'b0) begin bad++; $display("FAIL midrst_ped: ped=%b walk=%b required 0 0", ped_pending, walk); end
        @(negedge clk); rst = 1'b0;
        run_phase(n);
        total++; if (n !== 1 || phase !== 3'd0) begin bad++; $display("FAIL midrst_resume: %0d pulses to phase %0d required 1 to 0", n, phase); end
    endtask

    task automatic test_shorten();
        int unsigned n;
        repeat (2) next_pulse();
        @(negedge clk); ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
        run_phase(n);
        total++; if (n + 2 !== EXP_PED_GREEN || phase !== 3'd1) begin
            bad++; $display("FAIL shorten: %0d pulses to phase %0d required %0d to 1", n + 2, phase, EXP_PED_GREEN);
        end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ped_walk();
        test_priority();
        test_priority_ped();
        test_reset_mid();
        test_shorten();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Sequences a two-road intersection (NS and EW heads) and a pedestrian WALK phase from a shared 1 s pulse.
- The two roads share the intersection: this block grants green to one road at a time, inserts yellow and all-red clearance, and schedules pedestrian service.
- Sits above the per-head light drivers, consuming the same 1 s timebase the single-head controller uses.

Parameters:
- GREEN_S, 10: green duration per road, in 1 s pulses (1..2^CNT_W-1).
- YELLOW_S, 2: yellow duration, in pulses.
- ALL_RED_S, 1: all-red clearance duration, in pulses.
- WALK_S, 8: pedestrian WALK duration, in pulses.
- CNT_W, 5: phase timer width; must hold the largest duration.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- pulse_1s  in  1  one-clk-wide pulse every second.
- ped_req  in  1  pedestrian button; any high clk sets the request.
- priority_ns  in  1  while high, NS green is held past GREEN_S.
- ns_light  out  3  {red,yellow,green}, one-hot.
- ew_light  out  3  {red,yellow,green}, one-hot.
- walk  out  1  pedestrian WALK indication.
- ped_pending  out  1  latched pedestrian request not yet served.
- phase  out  3  current phase encoding, for debug/status.

Behaviour:
- Phases and encodings: NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_B=5, WALK=6. Encoding 7 is illegal and recovers to ALL_RED_B on the next clk.
- Phase timer t (CNT_W bits):
  - Cleared to 0 on every phase entry.
  - Increments on each pulse_1s.
  - A phase of duration D exits on the clk where pulse_1s=1 and t==D-1; the new phase is registered on that edge.
  - Each phase therefore lasts exactly D pulses.
- Transitions:
  - NS_GREEN -> NS_YELLOW at expiry, unless priority_ns=1 and ped_pending=0. In that case, stay and hold t at GREEN_S-1.
  - NS_YELLOW -> ALL_RED_A (YELLOW_S).
  - ALL_RED_A -> EW_GREEN (ALL_RED_S).
  - EW_GREEN -> EW_YELLOW (GREEN_S); priority_ns is ignored here.
  - EW_YELLOW -> ALL_RED_B (YELLOW_S).
  - ALL_RED_B -> WALK if ped_pending=1, else NS_GREEN (ALL_RED_S).
  - WALK -> NS_GREEN (WALK_S).
- Outputs are registered, decoded from the phase:
  - ns_light=green only in NS_GREEN, yellow only in NS_YELLOW, red otherwise.
  - ew_light likewise for the EW phases.
  - walk=1 only in WALK; both roads are red during WALK.
- Pedestrian request:
  - ped_pending sets on ped_req=1 in any phase except WALK.
  - It clears on the edge entering WALK.
  - ped_req during WALK is ignored.
  - Set and clear on the same edge: clear wins.
- Safety invariant: ns_light and ew_light are never both non-red in the same cycle.
- Reset:
  - phase=ALL_RED_B, t=0, ped_pending=0, walk=0, ns_light=ew_light=red (3'b100).
  - The first NS_GREEN follows after ALL_RED_S pulses.
  - rst mid-phase aborts immediately to the reset state on the next edge.
- pulse_1s and a phase change on the same clk: the pulse counts toward the old phase only; the new phase starts at t=0.

Optional Feature:
- Macro: TRAFFIC_PED_SHORTEN_EN.
- Defined: in NS_GREEN or EW_GREEN, if ped_pending=1 and t>=GREEN_S/2 (integer division), the green exits on the next pulse_1s. This overrides priority_ns. Normal yellow and all-red clearance still follow.
- Undefined: greens always run the full GREEN_S; no early termination.

Decomposition:
- Shared package traffic_pkg holds:
  - phase encodings (the 3-bit localparams above);
  - light one-hot constants LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001;
  - the default durations.
- One sub-module, phase_timer: CNT_W counter with inputs clear, tick, dur and output expire (tick && t==dur-1), plus a hold input that freezes t at dur-1.
- The scheduler FSM instantiates phase_timer once.

Test Plan:
1. Bench uses pulse_1s every 4 clks. Reset, no requests -> phase sequence 5,0,1,2,3,4,5,0 with pulse counts 1,10,2,1,10,2,1; lights one-hot; never both roads non-red.
2. ped_req one clk during EW_GREEN -> ped_pending=1 next clk; after ALL_RED_B, WALK for 8 pulses with walk=1 and both roads red; ped_pending=0 on WALK entry; then NS_GREEN.
3. priority_ns=1 held for 15 pulses from NS_GREEN entry -> NS green lasts 15 pulses; NS_YELLOW begins the pulse after priority_ns drops.
4. priority_ns=1 and ped_req during NS_GREEN -> priority is overridden; NS_YELLOW at pulse 10.
5. rst asserted for 1 clk mid-EW_GREEN (t=4) -> next edge phase=5, ew_light=red, ped_pending=0; NS_GREEN after 1 pulse.
6. With TRAFFIC_PED_SHORTEN_EN: ped_req at NS_GREEN t=2 -> exit at the pulse where t=5 (6 greens total). Without the macro: 10 pulses.
